// File: rtl/rle_stream_packer_pkg.sv
// Shared definitions for the run-length record path: record layout,
// serializer state encoding and a helper that assembles a record.
package rle_stream_packer_pkg;

  localparam int REC_W    = 8;
  localparam int CODE_W   = 4;
  localparam int RL_MSB   = 7;
  localparam int RL_LSB   = 4;
  localparam int CODE_MSB = 3;
  localparam int CODE_LSB = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Run length occupies the upper nibble so it leaves the serializer first.
  function automatic logic [REC_W-1:0] packRecord(logic [CODE_W-1:0] runLength,
                                                  logic [CODE_W-1:0] codeVal);
    logic [REC_W-1:0] rec;
    rec = '0;
    rec[RL_MSB:RL_LSB]     = runLength;
    rec[CODE_MSB:CODE_LSB] = codeVal;
    return rec;
  endfunction

endpackage

// File: rtl/rle_record_fifo.sv
// Small synchronous FIFO for packed records. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
module rle_record_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         doPush, doPop;

  // Guard the handshakes so a careless caller cannot overrun or underrun.
  always_comb begin
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    empty_o = (wptr_q == rptr_q);
    doPush  = push_i && !full_o;
    doPop   = pop_i && !empty_o;
    level_o = wptr_q - rptr_q;
    rdata_o = mem_q[rptr_q[AW-1:0]];
  end

  // Pointer update; reset discards every stored record.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (doPush) wptr_q <= wptr_q + 1'b1;
      if (doPop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage array needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/rle_stream_packer.sv
// Packs {run_length, code} records into a FIFO, drops empty runs, and
// shifts each record out MSB-first on a 1-bit valid/ready channel while
// counting completed records with a saturating counter.
module rle_stream_packer
  import rle_stream_packer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  input  logic [CODE_W-1:0]      code,
  input  logic [CODE_W-1:0]      run_length,
  output logic                   so_bit,
  output logic                   so_valid,
  input  logic                   so_ready,
  output logic                   so_last,
  output logic [CNT_W-1:0]       rec_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  state_e           state_q, state_d;
  logic [REC_W-1:0] shreg_q, shreg_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] reccnt_q, reccnt_d;

  logic             fifoFull, fifoEmpty, fifoPush, fifoPop;
  logic [REC_W-1:0] fifoRdata;

  // Zero-length runs are acknowledged upstream but never stored.
  always_comb begin
    sym_ready = reset && !fifoFull;
    fifoPush  = sym_valid && sym_ready && (run_length != '0);
  end

  rle_record_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .wdata_i (packRecord(run_length, code)),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fifo_level)
  );

  // Serializer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus shifter/counter updates; the last bit of a record
  // reloads from the FIFO in the same cycle so records run back to back.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    reccnt_d = reccnt_q;
    fifoPop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop  = 1'b1;
          shreg_d  = fifoRdata;
          bitcnt_d = 3'd0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (so_ready) begin
          if (bitcnt_q != 3'd7) begin
            shreg_d  = {shreg_q[REC_W-2:0], 1'b0};
            bitcnt_d = bitcnt_q + 3'd1;
          end else begin
            if (reccnt_q != '1) reccnt_d = reccnt_q + CNT_W'(1);
            if (!fifoEmpty) begin
              fifoPop  = 1'b1;
              shreg_d  = fifoRdata;
              bitcnt_d = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; a reset abandons any record in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      reccnt_q <= '0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      reccnt_q <= reccnt_d;
    end
  end

  // Serial channel outputs are driven only while shifting.
  always_comb begin
    so_valid  = (state_q == SHIFT);
    so_bit    = (state_q == SHIFT) && shreg_q[REC_W-1];
    so_last   = (state_q == SHIFT) && (bitcnt_q == 3'd7);
    rec_count = reccnt_q;
  end

endmodule

// File: tb/tb_rle_stream_packer.sv
// Scoreboard bench for rle_stream_packer: the stimulus side pushes the
// expected bit stream of each accepted record, a monitor pops and compares
// every bit the packer hands over, and bookkeeping of records in flight
// cross-checks occupancy and the completed-record counters.
module tb_rle_stream_packer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sym_valid = 1'b0;
  logic [3:0]       code = '0;
  logic [3:0]       run_length = '0;
  logic             so_ready = 1'b0;
  logic             sym_ready, so_bit, so_valid, so_last;
  logic [CNT_W-1:0] rec_count;
  logic [2:0]       fifo_level;

  logic             symReadyS, soBitS, soValidS, soLastS;
  logic [1:0]       recCountS;
  logic [2:0]       fifoLevelS;

  int checks = 0;
  int errors = 0;
  int acceptedCnt = 0;
  int completedCnt = 0;
  bit expBits[$];
  bit expLast[$];

  always #5 clk = ~clk;

  rle_stream_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .code(code), .run_length(run_length), .so_bit(so_bit), .so_valid(so_valid),
    .so_ready(so_ready), .so_last(so_last), .rec_count(rec_count),
    .fifo_level(fifo_level)
  );

  // Narrow-counter copy driven in lockstep so saturation is reachable quickly.
  rle_stream_packer #(.DEPTH(DEPTH), .CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_ready(symReadyS),
    .code(code), .run_length(run_length), .so_bit(soBitS), .so_valid(soValidS),
    .so_ready(so_ready), .so_last(soLastS), .rec_count(recCountS),
    .fifo_level(fifoLevelS)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus; reports whether the offered record transfers at
  // the coming edge and, if it is non-empty, queues its expected bits.
  task automatic applyStimulus(input bit v, input logic [3:0] rl, input logic [3:0] cd,
                               input bit rdy, output bit accepted);
    logic [7:0] rec;
    @(posedge clk);
    #1;
    sym_valid  = v;
    run_length = rl;
    code       = cd;
    so_ready   = rdy;
    @(negedge clk);
    accepted = v && sym_ready;
    if (accepted && rl != 0) begin
      rec = {rl, cd};
      for (int i = 7; i >= 0; i--) begin
        expBits.push_back(rec[i]);
        expLast.push_back(i == 0);
      end
    end
  endtask

  // Monitor: compare each presented bit, then account for transfers
  // happening at the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("in_flight", int'(fifo_level) + int'(so_valid), acceptedCnt - completedCnt);
      checkOutput("sym_ready_vs_level", sym_ready, fifo_level != DEPTH);
      checkOutput("rec_count", rec_count, completedCnt);
      checkOutput("rec_count_sat", recCountS, (completedCnt > 3) ? 3 : completedCnt);
      if (so_valid) begin
        if (expBits.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          checkOutput("so_bit", so_bit, expBits[0]);
          checkOutput("so_last", so_last, expLast[0]);
          if (so_ready) begin
            if (expLast[0]) completedCnt++;
            void'(expBits.pop_front());
            void'(expLast.pop_front());
          end
        end
      end
      if (sym_valid && sym_ready && run_length != 0) acceptedCnt++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit acc;
    int n, cnt;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_so_valid", so_valid, 0);
    checkOutput("rst_so_bit", so_bit, 0);
    checkOutput("rst_so_last", so_last, 0);
    checkOutput("rst_rec_count", rec_count, 0);
    checkOutput("rst_fifo_level", fifo_level, 0);
    checkOutput("rst_sym_ready", sym_ready, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single record: valid appears two edges after acceptance, 8 contiguous bits
    applyStimulus(1, 4'h3, 4'hA, 1, acc);
    checkOutput("first_accept", acc, 1);
    applyStimulus(0, 0, 0, 1, acc);
    checkOutput("latency_n", so_valid, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 1, acc);
      checkOutput("record_valid", so_valid, 1);
    end
    applyStimulus(0, 0, 0, 1, acc);
    checkOutput("back_to_idle", so_valid, 0);
    checkOutput("first_rec_count", rec_count, 1);

    // Empty run is consumed but never emitted
    applyStimulus(1, 4'h0, 4'h5, 1, acc);
    checkOutput("zero_accept", acc, 1);
    repeat (3) begin
      applyStimulus(0, 0, 0, 1, acc);
      checkOutput("zero_level", fifo_level, 0);
      checkOutput("zero_valid", so_valid, 0);
    end
    checkOutput("zero_rec_count", rec_count, 1);

    // Backpressure fill: one record sits in the shifter, DEPTH in the FIFO
    n = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 4'($urandom_range(1, 15)), 4'($urandom), 0, acc);
      if (!acc) break;
      n++;
    end
    checkOutput("fill_count", n, DEPTH + 1);
    checkOutput("fill_level", fifo_level, DEPTH);
    checkOutput("fill_sym_ready", sym_ready, 0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 0, 0, 1, acc);
      if (so_valid) cnt++;
      else break;
    end
    checkOutput("no_bubble_cycles", cnt, 8 * n);

    // Stall-heavy record: bits must hold while not ready
    applyStimulus(1, 4'h9, 4'hC, 1, acc);
    checkOutput("toggle_accept", acc, 1);
    for (int i = 0; i < 24; i++) applyStimulus(0, 0, 0, (i % 2) == 0, acc);
    checkOutput("toggle_drained", expBits.size(), 0);

    // Reset in the middle of a record with more queued behind it
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4'($urandom_range(1, 15)), 4'($urandom), 0, acc);
      checkOutput("pre_reset_accept", acc, 1);
    end
    applyStimulus(0, 0, 0, 0, acc);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, acc);
    applyStimulus(0, 0, 0, 0, acc);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_so_valid", so_valid, 0);
    checkOutput("async_level", fifo_level, 0);
    checkOutput("async_rec_count", rec_count, 0);
    checkOutput("async_sym_ready", sym_ready, 0);
    expBits.delete();
    expLast.delete();
    acceptedCnt  = 0;
    completedCnt = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 0, 1, acc);
      checkOutput("post_reset_quiet", so_valid, 0);
    end

    // Randomised traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom), ($urandom % 4 == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                    4'($urandom), ($urandom % 4) != 0, acc);
    end
    for (int i = 0; i < 400; i++) begin
      applyStimulus(0, 0, 0, 1, acc);
      if (expBits.size() == 0 && !so_valid) break;
    end
    checkOutput("final_drain", expBits.size(), 0);
    checkOutput("final_idle", so_valid, 0);
    checkOutput("final_sat", recCountS, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
